tipi_readback_mux: RTL
======================

# tipi_readback_mux

Parametrised, registered read-back multiplexer for the TIPI PEB CPLD data path. It selects one of CHANNELS WIDTH-bit register sources from the decoded address selects. The result is captured into an output register on the start of a TI read cycle and held stable for the rest of that cycle. It drives zero when nothing is selected or no read is active. It also flags address-decode collisions and counts completed reads for diagnostics. It sits between the register bank or latches and the TI data bus driver, and replaces the fixed 4×8 combinational selector.

## Interface
Parameters:
- WIDTH, 8, data width per channel (1..32)
- CHANNELS, 4, number of selectable sources (2..16)
- SYNC, 2, synchroniser stages on rd (1..3)
- HOLD, 1, 1 = freeze dout for the whole read cycle; 0 = dout re-evaluated every cycle while the read is active

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- rd  in  1  TI read-cycle enable, asynchronous to clk
- sel  in  CHANNELS  address-decode selects; bit i selects channel i
- din  in  CHANNELS*WIDTH  channel data; channel i = din[i*WIDTH +: WIDTH]
- clr_collision  in  1  clears the collision flag
- dout  out  WIDTH  registered read data
- dout_valid  out  1  dout holds a selected channel's data
- chan  out  $clog2(CHANNELS)  index of the channel captured into dout
- collision  out  1  sticky flag: more than one sel bit was set at a capture or tracking edge
- rd_count  out  16  count of completed read cycles; wraps

## Operation
- rd passes through a SYNC-deep flop chain; rd_s is the last stage. rd_q is rd_s delayed one cycle.
- sel and din are sampled directly, without synchronisation. The upstream guarantees they are stable from before rd rises until after it falls.
- Selection rule: the lowest-index set bit of sel wins (priority, not OR-merge).
- State machine, states IDLE and ACTIVE:
  - IDLE, rd_s=1: capture and go to ACTIVE.
    - Any sel bit set: dout = winning channel's data, chan = its index, dout_valid = 1.
    - No sel bit set: dout = 0, chan = 0, dout_valid = 0.
  - ACTIVE, rd_s=1, HOLD=1: dout, chan and dout_valid unchanged.
  - ACTIVE, rd_s=1, HOLD=0: apply the capture rule again each cycle.
  - ACTIVE, rd_s=0: dout = 0, dout_valid = 0, chan = 0, rd_count += 1 (mod 2^16), go to IDLE.
- collision:
  - Set on any capture or tracking edge where popcount(sel) > 1.
  - Cleared by clr_collision.
  - Set and clear in the same cycle: set wins.
- Reset, including mid-read:
  - dout = 0, dout_valid = 0, chan = 0, collision = 0, rd_count = 0, sync chain = 0, state = IDLE.
  - A read in progress at reset is not counted.
  - If rd is still high after reset, a fresh capture occurs once the synchroniser refills.

## Timing
- rd rising, set up before edge E0: rd_s = 1 after edge E0+SYNC-1; dout and dout_valid update at edge E0+SYNC.
- rd falling, set up before edge F0: dout returns to 0 at edge F0+SYNC.
- Minimum read pulse is one clk period. Pulses shorter than that may be missed; this is permitted and not counted.
- dout is always a flop output; there is no combinational path from sel or din to dout.
- Back-to-back reads: IDLE lasts at least one cycle between reads, so each rd pulse increments rd_count exactly once.

## Test plan
- Reset: assert reset 2 cycles with rd=1 and sel=4'b0001 -> dout=8'h00, dout_valid=0, collision=0, rd_count=0. Release reset -> capture 8'haa at SYNC edges later.
- Single selects: din = {dd,cc,bb,aa}, SYNC=2. For each sel of 0001, 0010, 0100, 1000, raise rd -> dout = aa/bb/cc/dd and chan = 0/1/2/3 exactly 2 edges after rd. After rd falls, dout=00 2 edges later. Final rd_count=4.
- No selection: sel=0, pulse rd -> dout=00, dout_valid=0, rd_count increments by 1.
- Priority and collision: sel=4'b0110 -> dout=bb, chan=1, collision=1. Collision stays 1 after rd falls. Pulse clr_collision -> 0. Pulse clr_collision while sel=0011 is captured -> collision=1.
- Hold vs track: HOLD=1, change din[7:0] from aa to 55 mid-read -> dout stays aa. HOLD=0, same stimulus -> dout=55 one edge after the change.
- Wrap and mid-read reset: preload 65535 reads, then one more -> rd_count=0. Assert reset during ACTIVE -> all outputs 0 next edge, and that read is not counted.

Source files
------------

// File: rtl/tipi_readback_mux.sv
// Registered read-back multiplexer for the TIPI PEB CPLD data path.
// Captures the lowest-index selected source on each synchronised TI read cycle.
module tipi_readback_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SYNC     = 2,
  parameter int HOLD     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd,
  input  logic [CHANNELS-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0]     din,
  input  logic                          clr_collision,
  output logic [WIDTH-1:0]              dout,
  output logic                          dout_valid,
  output logic [$clog2(CHANNELS)-1:0]   chan,
  output logic                          collision,
  output logic [15:0]                   rd_count
);

  localparam int CW = $clog2(CHANNELS);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t            state;
  logic [SYNC-1:0]   rd_sync;
  logic              rd_s;

  logic [WIDTH-1:0]  pick_data;
  logic [CW-1:0]     pick_idx;
  logic              pick_hit;
  logic              pick_multi;
  logic              sample_edge;
  logic              collision_set;

  assign rd_s = rd_sync[SYNC-1];

  // Lowest index wins; any further set bit marks a decode collision.
  always_comb begin
    pick_data  = '0;
    pick_idx   = '0;
    pick_hit   = 1'b0;
    pick_multi = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel[i]) begin
        if (pick_hit) begin
          pick_multi = 1'b1;
        end else begin
          pick_data = din[i*WIDTH +: WIDTH];
          pick_idx  = CW'(i);
        end
        pick_hit = 1'b1;
      end
    end
  end

  assign sample_edge   = rd_s && ((state == IDLE) || (HOLD == 0));
  assign collision_set = sample_edge && pick_multi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_sync    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      chan       <= '0;
      collision  <= 1'b0;
      rd_count   <= '0;
    end else begin
      rd_sync[0] <= rd;
      for (int unsigned i = 1; i < SYNC; i++) begin
        rd_sync[i] <= rd_sync[i-1];
      end

      collision <= collision_set | (collision & ~clr_collision);

      case (state)
        IDLE: begin
          if (rd_s) begin
            dout       <= pick_data;
            chan       <= pick_idx;
            dout_valid <= pick_hit;
            state      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!rd_s) begin
            dout       <= '0;
            chan       <= '0;
            dout_valid <= 1'b0;
            rd_count   <= rd_count + 16'd1;
            state      <= IDLE;
          end else if (HOLD == 0) begin
            dout       <= pick_data;
            chan       <= pick_idx;
            dout_valid <= pick_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
